// File: rtl/controlador_pkg.sv
// Shared definitions for the parametrised ATM transaction controller.
// Holds the 2-bit controller state encoding and the transaction type codes.
package controlador_pkg;

   typedef enum logic [1:0] {
      ESPERA_TARJETA = 2'd0,
      LEER_PIN       = 2'd1,
      ESPERA_MONTO   = 2'd2,
      BLOQUEADO      = 2'd3
   } estado_t;

   localparam logic TIPO_DEPOSITO = 1'b0;
   localparam logic TIPO_RETIRO   = 1'b1;

endpackage

// File: rtl/temporizador_sesion.sv
// Session inactivity timer: counts enabled cycles since the last clear.
// expired is combinational and flags the cycle whose edge completes TIMEOUT_CYC idle cycles.
module temporizador_sesion #(
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear || !enable) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_W'(TIMEOUT_CYC)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // The owner gives accepted strobes priority over expiry, so no gating by clear here.
   assign expired = enable && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/controlador_cajero_param.sv
// ATM controller: card, PIN entry with lockout, deposit/withdrawal on an internal balance.
// All outputs registered, pulses one cycle after the qualifying strobe; no backpressure, one strobe per cycle.
module controlador_cajero_param
   import controlador_pkg::*;
#(
   parameter int unsigned       PIN_DIGITS   = 4,
   parameter int unsigned       MONTO_W      = 32,
   parameter int unsigned       BAL_W        = 64,
   parameter int unsigned       MAX_TRIES    = 3,
   parameter int unsigned       TIMEOUT_CYC  = 1024,
   parameter logic [BAL_W-1:0]  INIT_BALANCE = BAL_W'(1000)
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    TARJETA_RECIBIDA,
   input  logic                    TIPO_TRANS,
   input  logic                    DIGITO_STB,
   input  logic [3:0]              DIGITO,
   input  logic [4*PIN_DIGITS-1:0] PIN,
   input  logic                    MONTO_STB,
   input  logic [MONTO_W-1:0]      MONTO,
   output logic                    BALANCE_ACTUALIZADO,
   output logic                    ENTREGAR_DINERO,
   output logic                    PIN_INCORRECTO,
   output logic                    ADVERTENCIA,
   output logic                    BLOQUEO,
   output logic                    FONDOS_INSUFICIENTES,
   output logic                    TIEMPO_AGOTADO,
   output logic [BAL_W-1:0]        BALANCE
);

   localparam int unsigned PIN_W  = 4 * PIN_DIGITS;
   localparam int unsigned DCNT_W = $clog2(PIN_DIGITS + 1);
   localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);

   estado_t           estado_q, estado_d;
   logic              tipo_q, tipo_d;
   logic [DCNT_W-1:0] dcnt_q, dcnt_d;
   logic [PIN_W-1:0]  pin_sh_q, pin_sh_d;
   logic [TRY_W-1:0]  tries_q, tries_d;
   logic [BAL_W-1:0]  balance_q, balance_d;
   logic              bal_act_q, bal_act_d;
   logic              entregar_q, entregar_d;
   logic              pin_inc_q, pin_inc_d;
   logic              adv_q, adv_d;
   logic              bloqueo_q, bloqueo_d;
   logic              fondos_q, fondos_d;
   logic              tout_q, tout_d;

   logic              tmr_en, tmr_clear, tmr_exp;
   logic [PIN_W-1:0]  pin_shifted;
   logic [TRY_W-1:0]  tries_inc;
   logic [BAL_W-1:0]  monto_ext;
   logic [BAL_W:0]    suma;

   assign tmr_en    = (estado_q == LEER_PIN) || (estado_q == ESPERA_MONTO);
   assign tmr_clear = ((estado_q == LEER_PIN) && DIGITO_STB) ||
                      ((estado_q == ESPERA_MONTO) && MONTO_STB);

   temporizador_sesion #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_temporizador (
      .clk     (CLK),
      .rst_n   (RESET),
      .clear   (tmr_clear),
      .enable  (tmr_en),
      .expired (tmr_exp)
   );

   assign pin_shifted = (pin_sh_q << 4) | PIN_W'(DIGITO);
   assign tries_inc   = tries_q + TRY_W'(1);
   assign monto_ext   = BAL_W'(MONTO);
   assign suma        = {1'b0, balance_q} + {1'b0, monto_ext};

   always_comb begin
      estado_d   = estado_q;
      tipo_d     = tipo_q;
      dcnt_d     = dcnt_q;
      pin_sh_d   = pin_sh_q;
      tries_d    = tries_q;
      balance_d  = balance_q;
      adv_d      = adv_q;
      bloqueo_d  = bloqueo_q;
      bal_act_d  = 1'b0;
      entregar_d = 1'b0;
      pin_inc_d  = 1'b0;
      fondos_d   = 1'b0;
      tout_d     = 1'b0;

      case (estado_q)
         ESPERA_TARJETA: begin
            if (TARJETA_RECIBIDA) begin
               estado_d = LEER_PIN;
               tipo_d   = TIPO_TRANS;
               dcnt_d   = '0;
            end
         end
         LEER_PIN: begin
            if (DIGITO_STB) begin
               pin_sh_d = pin_shifted;
               if (dcnt_q == DCNT_W'(PIN_DIGITS - 1)) begin
                  dcnt_d = '0;
                  if (pin_shifted == PIN) begin
                     estado_d = ESPERA_MONTO;
                     tries_d  = '0;
                     adv_d    = 1'b0;
                  end else begin
                     tries_d   = tries_inc;
                     pin_inc_d = 1'b1;
                     if (tries_inc == TRY_W'(MAX_TRIES)) begin
                        bloqueo_d = 1'b1;
                        adv_d     = 1'b0;
                        estado_d  = BLOQUEADO;
                     end else if (tries_inc == TRY_W'(MAX_TRIES - 1)) begin
                        adv_d = 1'b1;
                     end
                  end
               end else begin
                  dcnt_d = dcnt_q + DCNT_W'(1);
               end
            end else if (tmr_exp) begin
               tout_d   = 1'b1;
               estado_d = ESPERA_TARJETA;
            end
         end
         ESPERA_MONTO: begin
            if (MONTO_STB) begin
               estado_d = ESPERA_TARJETA;
               case (tipo_q)
                  TIPO_DEPOSITO: begin
                     // Saturate at all-ones rather than wrapping the account.
                     balance_d = suma[BAL_W] ? '1 : suma[BAL_W-1:0];
                     bal_act_d = 1'b1;
                  end
                  TIPO_RETIRO: begin
                     if (monto_ext > balance_q) begin
                        fondos_d = 1'b1;
                     end else begin
                        balance_d  = balance_q - monto_ext;
                        bal_act_d  = 1'b1;
                        entregar_d = 1'b1;
                     end
                  end
               endcase
            end else if (tmr_exp) begin
               tout_d   = 1'b1;
               estado_d = ESPERA_TARJETA;
            end
         end
         BLOQUEADO: begin
            estado_d = BLOQUEADO;
         end
         default: begin
            estado_d = ESPERA_TARJETA;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         estado_q   <= ESPERA_TARJETA;
         tipo_q     <= TIPO_DEPOSITO;
         dcnt_q     <= '0;
         pin_sh_q   <= '0;
         tries_q    <= '0;
         balance_q  <= INIT_BALANCE;
         bal_act_q  <= 1'b0;
         entregar_q <= 1'b0;
         pin_inc_q  <= 1'b0;
         adv_q      <= 1'b0;
         bloqueo_q  <= 1'b0;
         fondos_q   <= 1'b0;
         tout_q     <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         tipo_q     <= tipo_d;
         dcnt_q     <= dcnt_d;
         pin_sh_q   <= pin_sh_d;
         tries_q    <= tries_d;
         balance_q  <= balance_d;
         bal_act_q  <= bal_act_d;
         entregar_q <= entregar_d;
         pin_inc_q  <= pin_inc_d;
         adv_q      <= adv_d;
         bloqueo_q  <= bloqueo_d;
         fondos_q   <= fondos_d;
         tout_q     <= tout_d;
      end
   end

   assign BALANCE_ACTUALIZADO  = bal_act_q;
   assign ENTREGAR_DINERO      = entregar_q;
   assign PIN_INCORRECTO       = pin_inc_q;
   assign ADVERTENCIA          = adv_q;
   assign BLOQUEO              = bloqueo_q;
   assign FONDOS_INSUFICIENTES = fondos_q;
   assign TIEMPO_AGOTADO       = tout_q;
   assign BALANCE              = balance_q;

endmodule

// File: tb/tb_controlador_cajero_param.sv
// Bench for controlador_cajero_param: a wide-balance and a 16-bit saturating instance share stimulus
// and are compared every cycle against a session-level model, plus directed literal checks.
module tb_controlador_cajero_param;

   localparam int N_DIG = 4;
   localparam int MAXT  = 3;
   localparam int TMO   = 16;
   localparam int P_IDLE = 0, P_PIN = 1, P_AMT = 2, P_LOCK = 3;

   logic        CLK;
   logic        RESET;
   logic        TARJETA_RECIBIDA, TIPO_TRANS, DIGITO_STB, MONTO_STB;
   logic [3:0]  DIGITO;
   logic [15:0] PIN;
   logic [31:0] MONTO;

   logic        act0, ent0, pinc0, adv0, blq0, fon0, tout0;
   logic [63:0] bal0;
   logic        act1, ent1, pinc1, adv1, blq1, fon1, tout1;
   logic [15:0] bal1;

   int n_checks = 0;
   int n_errors = 0;

   // Session-level model state
   int          m_phase, m_ndig, m_tries, m_idle, m_acc;
   logic        m_tipo;
   logic        e_adv, e_lock, e_pinbad, e_tout;
   logic        e_act [2];
   logic        e_ent [2];
   logic        e_fon [2];
   logic [63:0] e_bal [2];
   logic [63:0] bal_max [2];
   logic [63:0] bal_init [2];
   int          quiet;

   controlador_cajero_param #(
      .PIN_DIGITS(4), .MONTO_W(32), .BAL_W(64), .MAX_TRIES(3),
      .TIMEOUT_CYC(16), .INIT_BALANCE(64'd1000)
   ) dut0 (
      .CLK(CLK), .RESET(RESET), .TARJETA_RECIBIDA(TARJETA_RECIBIDA), .TIPO_TRANS(TIPO_TRANS),
      .DIGITO_STB(DIGITO_STB), .DIGITO(DIGITO), .PIN(PIN), .MONTO_STB(MONTO_STB), .MONTO(MONTO),
      .BALANCE_ACTUALIZADO(act0), .ENTREGAR_DINERO(ent0), .PIN_INCORRECTO(pinc0),
      .ADVERTENCIA(adv0), .BLOQUEO(blq0), .FONDOS_INSUFICIENTES(fon0),
      .TIEMPO_AGOTADO(tout0), .BALANCE(bal0)
   );

   controlador_cajero_param #(
      .PIN_DIGITS(4), .MONTO_W(16), .BAL_W(16), .MAX_TRIES(3),
      .TIMEOUT_CYC(16), .INIT_BALANCE(16'd65000)
   ) dut1 (
      .CLK(CLK), .RESET(RESET), .TARJETA_RECIBIDA(TARJETA_RECIBIDA), .TIPO_TRANS(TIPO_TRANS),
      .DIGITO_STB(DIGITO_STB), .DIGITO(DIGITO), .PIN(PIN), .MONTO_STB(MONTO_STB), .MONTO(MONTO[15:0]),
      .BALANCE_ACTUALIZADO(act1), .ENTREGAR_DINERO(ent1), .PIN_INCORRECTO(pinc1),
      .ADVERTENCIA(adv1), .BLOQUEO(blq1), .FONDOS_INSUFICIENTES(fon1),
      .TIEMPO_AGOTADO(tout1), .BALANCE(bal1)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = P_IDLE; m_ndig = 0; m_tries = 0; m_idle = 0; m_acc = 0; m_tipo = 1'b0;
      e_adv = 1'b0; e_lock = 1'b0; e_pinbad = 1'b0; e_tout = 1'b0;
      for (int k = 0; k < 2; k++) begin
         e_act[k] = 1'b0; e_ent[k] = 1'b0; e_fon[k] = 1'b0; e_bal[k] = bal_init[k];
      end
   endtask

   task automatic model_idle_tick();
      m_idle++;
      if (m_idle == TMO) begin
         e_tout  = 1'b1;
         m_phase = P_IDLE;
      end
   endtask

   // Predicts the outputs after the coming clock edge from the inputs now on the pins.
   task automatic model_step();
      logic [63:0] m;
      logic [64:0] s;
      e_pinbad = 1'b0; e_tout = 1'b0;
      for (int k = 0; k < 2; k++) begin
         e_act[k] = 1'b0; e_ent[k] = 1'b0; e_fon[k] = 1'b0;
      end
      case (m_phase)
         P_IDLE: if (TARJETA_RECIBIDA) begin
            m_phase = P_PIN; m_tipo = TIPO_TRANS; m_ndig = 0; m_idle = 0;
         end
         P_PIN: if (DIGITO_STB) begin
            m_idle = 0;
            m_acc  = (m_acc * 16 + int'(DIGITO)) % (1 << (4 * N_DIG));
            m_ndig++;
            if (m_ndig == N_DIG) begin
               m_ndig = 0;
               if (m_acc == int'(PIN)) begin
                  m_phase = P_AMT; m_tries = 0; e_adv = 1'b0;
               end else begin
                  m_tries++;
                  e_pinbad = 1'b1;
                  if (m_tries == MAXT) begin
                     e_lock = 1'b1; e_adv = 1'b0; m_phase = P_LOCK;
                  end else if (m_tries == MAXT - 1) begin
                     e_adv = 1'b1;
                  end
               end
            end
         end else model_idle_tick();
         P_AMT: if (MONTO_STB) begin
            for (int k = 0; k < 2; k++) begin
               m = (k == 0) ? 64'(MONTO) : 64'(MONTO[15:0]);
               if (m_tipo == 1'b0) begin
                  s = 65'(e_bal[k]) + 65'(m);
                  e_bal[k] = (s > 65'(bal_max[k])) ? bal_max[k] : s[63:0];
                  e_act[k] = 1'b1;
               end else if (m > e_bal[k]) begin
                  e_fon[k] = 1'b1;
               end else begin
                  e_bal[k] = e_bal[k] - m;
                  e_act[k] = 1'b1; e_ent[k] = 1'b1;
               end
            end
            m_phase = P_IDLE;
         end else model_idle_tick();
         default: ;
      endcase
   endtask

   task automatic compare_outputs();
      chk("cyc_flags0", {57'd0, act0, ent0, pinc0, adv0, blq0, fon0, tout0},
          {57'd0, e_act[0], e_ent[0], e_pinbad, e_adv, e_lock, e_fon[0], e_tout});
      chk("cyc_bal0", bal0, e_bal[0]);
      chk("cyc_flags1", {57'd0, act1, ent1, pinc1, adv1, blq1, fon1, tout1},
          {57'd0, e_act[1], e_ent[1], e_pinbad, e_adv, e_lock, e_fon[1], e_tout});
      chk("cyc_bal1", {48'd0, bal1}, e_bal[1]);
   endtask

   // One clock: compare on the falling edge, advance the model, then return just after the rising edge.
   task automatic step_cycle();
      @(negedge CLK);
      if (!RESET) model_reset();
      compare_outputs();
      if (RESET) model_step();
      @(posedge CLK);
      #1;
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) step_cycle();
   endtask

   task automatic card(input logic t);
      TARJETA_RECIBIDA = 1'b1; TIPO_TRANS = t;
      step_cycle();
      TARJETA_RECIBIDA = 1'b0;
   endtask

   task automatic digito(input logic [3:0] d);
      DIGITO_STB = 1'b1; DIGITO = d;
      step_cycle();
      DIGITO_STB = 1'b0;
   endtask

   task automatic pin4(input logic [15:0] p);
      for (int i = 3; i >= 0; i--) digito(p[4*i +: 4]);
   endtask

   task automatic monto(input logic [31:0] m);
      MONTO_STB = 1'b1; MONTO = m;
      step_cycle();
      MONTO_STB = 1'b0;
   endtask

   task automatic do_reset();
      RESET = 1'b0;
      step_cycle();
      RESET = 1'b1;
   endtask

   initial begin
      bal_max[0]  = 64'hFFFF_FFFF_FFFF_FFFF; bal_max[1]  = 64'd65535;
      bal_init[0] = 64'd1000;                bal_init[1] = 64'd65000;
      PIN = 16'h1234;
      TARJETA_RECIBIDA = 1'b0; TIPO_TRANS = 1'b0; DIGITO_STB = 1'b0; DIGITO = 4'd0;
      MONTO_STB = 1'b0; MONTO = 32'd0; quiet = 0;
      RESET = 1'b1;
      #1 RESET = 1'b0;
      #1;
      chk("rst_bal0", bal0, 64'd1000);
      chk("rst_bal1", {48'd0, bal1}, 64'd65000);
      chk("rst_flags", {57'd0, act0, ent0, pinc0, adv0, blq0, fon0, tout0}, 64'd0);
      step_cycle();
      step_cycle();
      RESET = 1'b1;

      // Withdrawal within funds
      card(1'b1); pin4(16'h1234); monto(32'd300);
      chk("wd_dispense", {62'd0, ent0, act0}, 64'd3);
      chk("wd_bal0", bal0, 64'd700);
      chk("wd_bal1", {48'd0, bal1}, 64'd64700);
      cyc(1);
      chk("wd_pulse_width", {62'd0, ent0, act0}, 64'd0);

      // Withdrawal refused
      do_reset();
      card(1'b1); pin4(16'h1234); monto(32'd2000);
      chk("nsf_flag", {62'd0, fon0, ent0}, 64'd2);
      chk("nsf_bal0", bal0, 64'd1000);

      // Saturating deposit on the 16-bit instance
      do_reset();
      card(1'b0); pin4(16'h1234); monto(32'd1000);
      chk("sat_bal1", {48'd0, bal1}, 64'd65535);
      chk("sat_act1", {63'd0, act1}, 64'd1);
      chk("dep_bal0", bal0, 64'd2000);

      // Lockout after three wrong PINs, inputs ignored afterwards
      do_reset();
      card(1'b1);
      pin4(16'h1235);
      chk("wrong1", {61'd0, pinc0, adv0, blq0}, 64'b100);
      pin4(16'h1235);
      chk("wrong2", {61'd0, pinc0, adv0, blq0}, 64'b110);
      pin4(16'h1235);
      chk("wrong3", {61'd0, pinc0, adv0, blq0}, 64'b101);
      cyc(2);
      card(1'b1); pin4(16'h1234); monto(32'd10);
      chk("locked_silent", {59'd0, act0, ent0, pinc0, fon0, blq0}, 64'b00001);
      chk("locked_bal0", bal0, 64'd1000);

      // Inactivity timeout and tries carried across it
      do_reset();
      card(1'b0); digito(4'd1); digito(4'd2);
      cyc(15);
      chk("tmo_early", {63'd0, tout0}, 64'd0);
      cyc(1);
      chk("tmo_pulse", {63'd0, tout0}, 64'd1);
      cyc(1);
      chk("tmo_width", {63'd0, tout0}, 64'd0);
      card(1'b0); pin4(16'h1235);
      chk("tmo_wrong1", {62'd0, pinc0, adv0}, 64'b10);
      cyc(16);
      chk("tmo_pulse2", {63'd0, tout0}, 64'd1);
      card(1'b0); pin4(16'h1235);
      chk("tmo_carry_adv", {62'd0, pinc0, adv0}, 64'b11);

      // Asynchronous reset mid-session
      do_reset();
      card(1'b1); pin4(16'h1234); monto(32'd300);
      card(1'b1); pin4(16'h1235); digito(4'd1); digito(4'd2);
      #1 RESET = 1'b0;
      #1;
      chk("arst_bal0", bal0, 64'd1000);
      chk("arst_bal1", {48'd0, bal1}, 64'd65000);
      chk("arst_flags", {57'd0, act0, ent0, pinc0, adv0, blq0, fon0, tout0}, 64'd0);
      step_cycle();
      RESET = 1'b1;
      card(1'b1); pin4(16'h1234); monto(32'd100);
      chk("arst_after_bal0", bal0, 64'd900);
      chk("arst_after_ent0", {63'd0, ent0}, 64'd1);

      // Randomised traffic, biased toward correct digits, with idle stretches and sparse resets
      for (int n = 0; n < 4000; n++) begin
         RESET = ($urandom_range(0, 199) != 0);
         if (quiet > 0) begin
            quiet--;
            TARJETA_RECIBIDA = 1'b0; DIGITO_STB = 1'b0; MONTO_STB = 1'b0;
         end else begin
            if ($urandom_range(0, 59) == 0) quiet = $urandom_range(12, 20);
            TARJETA_RECIBIDA = ($urandom_range(0, 3) == 0);
            TIPO_TRANS = 1'($urandom);
            DIGITO_STB = ($urandom_range(0, 2) != 0);
            if (m_phase == P_PIN && $urandom_range(0, 9) != 0)
               DIGITO = PIN[4*(N_DIG-1-m_ndig) +: 4];
            else
               DIGITO = 4'($urandom);
            MONTO_STB = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
               0: MONTO = $urandom_range(0, 50);
               1: MONTO = $urandom_range(0, 2000);
               2: MONTO = $urandom;
               default: MONTO = $urandom_range(60000, 65535);
            endcase
         end
         step_cycle();
      end
      RESET = 1'b1;
      TARJETA_RECIBIDA = 1'b0; DIGITO_STB = 1'b0; MONTO_STB = 1'b0;
      cyc(2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
